// File: rtl/dma_line_packer.sv
// -----------------------------------------------------------------------------
// dma_line_packer
//   Packs narrow DRAM read-response beats (BEAT words each) into full
//   VSIZE-word SRAM lines and emits each completed line as a one-cycle
//   dma_write strobe (line address + line data) towards the RemapCache
//   write port. A job is one allocated region: a base line address and a
//   word count. A job of zero words completes immediately without writes.
//
//   Optional feature macro: DMA_PAD_EN
//     defined   : lanes of the final line beyond the job's word count are
//                 filled with the pad value latched at job_ack.
//     undefined : those lanes keep stale buffer contents.
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   job_rdy/job_ack  job handshake (ack combinational, IDLE only)
//   i_job_hiaddr     first SRAM line address of the job
//   i_job_nword      words in the job (0..2^LBW)
//   i_pad_value      pad word, sampled at job_ack
//   beat_rdy/beat_ack DRAM beat handshake (ack combinational, FILL only)
//   i_beat_data      BEAT words, lane 0 in the low DBW bits
//   dma_write_dval   one-cycle line-write strobe
//   o_dma_whiaddr    line address for the strobe
//   o_dma_wdata      line data for the strobe, lane 0 in the low DBW bits
//   done_dval        one-cycle job-complete strobe
//   o_busy           high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module dma_line_packer #(
  parameter  int LBW   = 10,
  parameter  int VSIZE = 32,
  parameter  int DBW   = 16,
  parameter  int BEAT  = 4,
  localparam int HBW   = LBW - $clog2(VSIZE)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 job_rdy,
  output logic                 job_ack,
  input  logic [HBW-1:0]       i_job_hiaddr,
  input  logic [LBW:0]         i_job_nword,
  input  logic [DBW-1:0]       i_pad_value,
  input  logic                 beat_rdy,
  output logic                 beat_ack,
  input  logic [BEAT*DBW-1:0]  i_beat_data,
  output logic                 dma_write_dval,
  output logic [HBW-1:0]       o_dma_whiaddr,
  output logic [VSIZE*DBW-1:0] o_dma_wdata,
  output logic                 done_dval,
  output logic                 o_busy
);

  localparam int OFFW = $clog2(VSIZE);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_ZERO} state_t;

  state_t                    r_state;
  logic [HBW-1:0]            r_hiaddr;
  logic [LBW:0]              r_nword;
  logic [LBW:0]              r_wptr;
  logic [VSIZE-1:0][DBW-1:0] r_line;
  logic [VSIZE-1:0][DBW-1:0] r_wdata;
  logic [HBW-1:0]            r_whiaddr;
  logic                      r_dval;
  logic                      r_done;

  logic                      w_beat_fire;
  logic                      w_last;
  logic                      w_line_end;
  logic [LBW:0]              w_wptr_next;
  logic [BEAT-1:0][DBW-1:0]  w_beat;
  logic [VSIZE-1:0][DBW-1:0] w_next_line;

`ifdef DMA_PAD_EN
  logic [DBW-1:0]            r_pad;
`else
  logic                      w_unused_pad;
  assign w_unused_pad = ^i_pad_value;
`endif

  // Job word index held by lane j of the line the pointer currently sits in.
  function automatic logic [LBW:0] lane_idx(input logic [LBW:0] wptr, input int j);
    return {wptr[LBW:OFFW], OFFW'(j)};
  endfunction

  assign w_beat      = i_beat_data;
  // Reset gates the acks so every output reads 0 while i_rst_n is low.
  assign job_ack     = i_rst_n && (r_state == S_IDLE) && job_rdy;
  assign beat_ack    = (r_state == S_FILL) && beat_rdy;
  assign w_beat_fire = beat_ack;
  assign w_wptr_next = r_wptr + (LBW+1)'(BEAT);
  assign w_last      = (w_wptr_next >= r_nword);
  assign w_line_end  = (r_wptr[OFFW-1:0] == OFFW'(VSIZE - BEAT));

  // Line buffer as it will look after the current beat lands. The flush
  // copies this merged view, so a line completes on the same edge as its
  // last beat and the next beat can land during the strobe cycle.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_next_line unassigned (no latch).
    w_next_line = r_line;
    for (int j = 0; j < VSIZE; j++) begin
      // Words past the job end are consumed but never written.
      if (w_beat_fire && ((j / BEAT) * BEAT == int'(r_wptr[OFFW-1:0])) &&
          (lane_idx(r_wptr, j) < r_nword))
        w_next_line[j] = w_beat[j % BEAT];
`ifdef DMA_PAD_EN
      if (w_beat_fire && w_last && (lane_idx(r_wptr, j) >= r_nword))
        w_next_line[j] = r_pad;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_hiaddr  <= '0;
      r_nword   <= '0;
      r_wptr    <= '0;
      // NOTE: the line buffer is ordinary flops rather than a RAM macro, so it
      // is cleared with the rest of the state and a reset drops a partial line.
      r_line    <= '0;
      r_wdata   <= '0;
      r_whiaddr <= '0;
      r_dval    <= 1'b0;
      r_done    <= 1'b0;
`ifdef DMA_PAD_EN
      r_pad     <= '0;
`endif
    end else begin
      // NOTE: state uses non-blocking updates so every branch sees pre-edge values.
      r_dval <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (job_ack) begin
            r_hiaddr <= i_job_hiaddr;
            r_nword  <= i_job_nword;
            r_wptr   <= '0;
`ifdef DMA_PAD_EN
            r_pad    <= i_pad_value;
`endif
            if (i_job_nword == '0) begin
              r_state <= S_ZERO;
              r_done  <= 1'b1;   // visible during the single ZERO cycle
            end else begin
              r_state <= S_FILL;
            end
          end
        end
        S_ZERO: r_state <= S_IDLE;
        S_FILL: begin
          if (w_beat_fire) begin
            r_line <= w_next_line;
            r_wptr <= w_wptr_next;
            if (w_line_end || w_last) begin
              r_wdata   <= w_next_line;
              r_whiaddr <= r_hiaddr;
              r_hiaddr  <= r_hiaddr + 1'b1;   // wraps silently at 2^HBW
              r_dval    <= 1'b1;
            end
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dma_write_dval = r_dval;
  assign o_dma_whiaddr  = r_whiaddr;
  assign o_dma_wdata    = r_wdata;
  assign done_dval      = r_done;
  assign o_busy         = (r_state != S_IDLE);

endmodule
